// File: rtl/scan_test_controller.sv
// scan_test_controller: drives one load/capture/unload scan test and compares the unloaded chain
module scan_test_controller #(
  parameter int CHAIN_LEN      = 4,
  parameter int CAPTURE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
  input  logic                 scan_out,
  output logic                 scan_en,
  output logic                 scan_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] captured
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SHIFT_IN  = 3'd1;
  localparam logic [2:0] CAPTURE   = 3'd2;
  localparam logic [2:0] SHIFT_OUT = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;
  localparam logic [4:0] LAST_SHIFT = 5'(CHAIN_LEN - 1);
  localparam logic [4:0] LAST_CAP   = 5'(CAPTURE_CYCLES - 1);
  logic [2:0] state, state_n;
  logic [4:0] phase;
  logic [CHAIN_LEN-1:0] pat_q, exp_q, cap_n;
  logic last, accept;
  always_comb begin
    last    = (state == CAPTURE) ? (phase == LAST_CAP) : (state == DONE) ? 1'b1 : (phase == LAST_SHIFT);
    accept  = (state == IDLE) && start && !abort;
    cap_n   = {captured[CHAIN_LEN-2:0], scan_out};
    state_n = (state == IDLE) ? (accept ? SHIFT_IN : IDLE) :
              abort ? IDLE :
              !last ? state :
              (state == SHIFT_IN) ? CAPTURE :
              (state == CAPTURE) ? SHIFT_OUT :
              (state == SHIFT_OUT) ? DONE : IDLE;
  end
  // pat_q doubles as the load shifter: its MSB is always the next bit to send
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      phase    <= '0;
      pat_q    <= '0;
      exp_q    <= '0;
      captured <= '0;
      pass     <= 1'b0;
    end else begin
      state <= state_n;
      phase <= (state_n != state || state == IDLE) ? 5'd0 : phase + 5'd1;
      if (accept) begin
        pat_q    <= pattern;
        exp_q    <= expected;
        captured <= '0;
        pass     <= 1'b0;
      end else if (state != IDLE && abort) begin
        captured <= '0;
        pass     <= 1'b0;
      end else if (state == SHIFT_IN) begin
        pat_q <= pat_q << 1;
      end else if (state == SHIFT_OUT) begin
        captured <= cap_n;
        if (last) pass <= (cap_n == exp_q);
      end
    end
  end
  assign scan_en = (state == SHIFT_IN) || (state == SHIFT_OUT);
  assign scan_in = (state == SHIFT_IN) && pat_q[CHAIN_LEN-1];
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
endmodule

// File: tb/tb_scan_test_controller.sv
// tb_scan_test_controller: scoreboard bench driving two controllers against a 4-bit incrementing scan counter
module tb_scan_test_controller;
  logic clk = 1'b0, rst = 1'b0, abort = 1'b0, start0 = 1'b0, start1 = 1'b0, sel = 1'b0;
  logic [3:0] pattern = '0, expected = '0, chain0 = '0, chain1 = '0, captured0, captured1;
  logic scan_en0, scan_in0, busy0, done0, pass0;
  logic scan_en1, scan_in1, busy1, done1, pass1;
  logic cur_en, cur_sin, cur_busy, cur_done, cur_pass;
  logic [3:0] cur_cap;
  logic [4:0] q0[$], q1[$];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  scan_test_controller u0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort), .pattern(pattern), .expected(expected),
    .scan_out(chain0[3]), .scan_en(scan_en0), .scan_in(scan_in0), .busy(busy0), .done(done0),
    .pass(pass0), .captured(captured0));

  scan_test_controller #(.CHAIN_LEN(4), .CAPTURE_CYCLES(3)) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort), .pattern(pattern), .expected(expected),
    .scan_out(chain1[3]), .scan_en(scan_en1), .scan_in(scan_in1), .busy(busy1), .done(done1),
    .pass(pass1), .captured(captured1));

  // scan chain model: shifts toward flop 3 under scan_en, counts up in functional mode
  always @(posedge clk) begin
    chain0 <= scan_en0 ? {chain0[2:0], scan_in0} : chain0 + 4'd1;
    chain1 <= scan_en1 ? {chain1[2:0], scan_in1} : chain1 + 4'd1;
  end

  always_comb begin
    cur_en   = sel ? scan_en1 : scan_en0;
    cur_sin  = sel ? scan_in1 : scan_in0;
    cur_busy = sel ? busy1 : busy0;
    cur_done = sel ? done1 : done0;
    cur_pass = sel ? pass1 : pass0;
    cur_cap  = sel ? captured1 : captured0;
  end

  always @(negedge clk) begin
    logic [4:0] e;
    if (done0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL sb0_unexpected_done got pass=%b captured=%b required no done", pass0, captured0);
      end else begin
        e = q0.pop_front();
        if ({pass0, captured0} !== e) begin
          errors++;
          $display("FAIL sb0_result got pass=%b captured=%b required pass=%b captured=%b", pass0, captured0, e[4], e[3:0]);
        end
      end
    end
    if (done1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL sb1_unexpected_done got pass=%b captured=%b required no done", pass1, captured1);
      end else begin
        e = q1.pop_front();
        if ({pass1, captured1} !== e) begin
          errors++;
          $display("FAIL sb1_result got pass=%b captured=%b required pass=%b captured=%b", pass1, captured1, e[4], e[3:0]);
        end
      end
    end
  end

  task automatic set_start(input logic s, input logic v);
    if (s) start1 = v;
    else start0 = v;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    start0 = 1'b1;
    start1 = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({scan_en0, scan_in0, busy0, done0, pass0, captured0} !== 9'd0) begin
      errors++;
      $display("FAIL reset_u0 got %b required 000000000", {scan_en0, scan_in0, busy0, done0, pass0, captured0});
    end
    checks++;
    if ({scan_en1, scan_in1, busy1, done1, pass1, captured1} !== 9'd0) begin
      errors++;
      $display("FAIL reset_u1 got %b required 000000000", {scan_en1, scan_in1, busy1, done1, pass1, captured1});
    end
    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy got %b%b required 00", busy0, busy1);
    end
  endtask

  // one full test on DUT s; caller is just past a negedge
  task automatic run_test(input logic s, input logic [3:0] p, input logic [3:0] e,
                          input logic [3:0] cap, input logic ps, input logic repulse);
    int c = s ? 3 : 1;
    int l = 8 + c + 1;
    int en_cnt = 0, low_cnt = 0, busy_cnt = 0, done_cnt = 0, done_at = 0;
    logic [3:0] got = '0;
    logic extra = 1'b0;
    sel = s;
    pattern = p;
    expected = e;
    set_start(s, 1'b1);
    if (s) q1.push_back({ps, cap});
    else q0.push_back({ps, cap});
    for (int k = 1; k <= l + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        set_start(s, 1'b0);
        pattern = ~p;
        expected = ~e;
      end
      if (repulse && k == 7) set_start(s, 1'b1);
      if (repulse && k == 8) set_start(s, 1'b0);
      if (k <= 4) got[4-k] = cur_sin;
      else extra |= cur_sin;
      en_cnt += int'(cur_en);
      if (k <= 8 + c && !cur_en) low_cnt++;
      busy_cnt += int'(cur_busy);
      if (cur_done) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
    end
    checks++;
    if (got !== p) begin errors++; $display("FAIL scan_in_seq got %b required %b", got, p); end
    checks++;
    if (extra !== 1'b0) begin errors++; $display("FAIL scan_in_idle got %b required 0", extra); end
    checks++;
    if (en_cnt != 8) begin errors++; $display("FAIL scan_en_cycles got %0d required 8", en_cnt); end
    checks++;
    if (low_cnt != c) begin errors++; $display("FAIL capture_cycles got %0d required %0d", low_cnt, c); end
    checks++;
    if (busy_cnt != l) begin errors++; $display("FAIL busy_cycles got %0d required %0d", busy_cnt, l); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL done_count got %0d required 1", done_cnt); end
    checks++;
    if (done_at != l) begin errors++; $display("FAIL done_latency got %0d required %0d", done_at, l); end
    checks++;
    if ({cur_pass, cur_cap} !== {ps, cap}) begin
      errors++;
      $display("FAIL result_held got pass=%b captured=%b required pass=%b captured=%b", cur_pass, cur_cap, ps, cap);
    end
  endtask

  task automatic test_basic;
    run_test(1'b0, 4'b0101, 4'b0110, 4'b0110, 1'b1, 1'b0);
  endtask

  task automatic test_wrap;
    run_test(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0);
    run_test(1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_capture3;
    run_test(1'b1, 4'b1110, 4'b0001, 4'b0001, 1'b1, 1'b0);
  endtask

  task automatic test_start_repulse;
    run_test(1'b0, 4'b1010, 4'b1011, 4'b1011, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back;
    run_test(1'b0, 4'b0011, 4'b0100, 4'b0100, 1'b1, 1'b0);
    run_test(1'b0, 4'b0111, 4'b0000, 4'b1000, 1'b0, 1'b0);
    run_test(1'b1, 4'b1001, 4'b1100, 4'b1100, 1'b1, 1'b0);
  endtask

  task automatic test_abort;
    int dones = 0;
    sel = 1'b0;
    pattern = 4'b0011;
    expected = 4'b0000;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({busy0, scan_en0, done0, pass0, captured0} !== 8'd0) begin
      errors++;
      $display("FAIL abort_state got %b required 00000000", {busy0, scan_en0, done0, pass0, captured0});
    end
    repeat (12) begin
      @(negedge clk);
      dones += int'(done0);
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL abort_no_done got %0d required 0", dones); end
    run_test(1'b0, 4'b0101, 4'b0110, 4'b0110, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    sel = 1'b1;
    pattern = 4'b1110;
    expected = 4'b0001;
    start1 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) start1 = 1'b0;
    end
    checks++;
    if ({busy1, scan_en1} !== 2'b10) begin
      errors++;
      $display("FAIL reset_mid_in_capture got busy,scan_en=%b required 10", {busy1, scan_en1});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({scan_en1, scan_in1, busy1, done1, pass1, captured1} !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid_state got %b required 000000000", {scan_en1, scan_in1, busy1, done1, pass1, captured1});
    end
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      dones += int'(done1);
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL reset_mid_no_done got %0d required 0", dones); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_capture3;
    test_start_repulse;
    test_back_to_back;
    test_abort;
    test_reset_mid;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d/%0d pending required 0/0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/scan_test_controller.md
SCAN_TEST_CONTROLLER -- requirements
Module: scan_test_controller

Interface
REQ-001 Parameter: CHAIN_LEN, default 4, number of scan flip-flops in the controlled chain (legal 2..16).
REQ-002 Parameter: CAPTURE_CYCLES, default 1, functional-mode clock cycles between load and unload (legal 1..15).
REQ-003 Port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-low reset, sampled on the clk rising edge.
REQ-005 Port: start  input  1  request one load/capture/unload test; sampled only in IDLE.
REQ-006 Port: abort  input  1  terminate the test in progress.
REQ-007 Port: pattern  input  CHAIN_LEN  stimulus vector; bit i targets chain flop i, where flop 0 is nearest scan_in.
REQ-008 Port: expected  input  CHAIN_LEN  expected captured chain state.
REQ-009 Port: scan_out  input  1  serial output of the last chain flop (flop CHAIN_LEN-1).
REQ-010 Port: scan_en  output  1  chain shift enable; 1 = shift, 0 = functional/capture.
REQ-011 Port: scan_in  output  1  serial data into chain flop 0.
REQ-012 Port: busy  output  1  high in every state except IDLE.
REQ-013 Port: done  output  1  single-cycle completion pulse.
REQ-014 Port: pass  output  1  compare result; valid from the done cycle, held until the next accepted start.
REQ-015 Port: captured  output  CHAIN_LEN  unloaded chain state; held until the next accepted start.

Function
REQ-016 FSM states: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE. scan_en, scan_in, busy and done decode only from registered state and registers, with no combinational path from any input.
REQ-017 IDLE with start=1 and abort=0: latch pattern and expected, clear captured, clear pass, enter SHIFT_IN. start in any other state is ignored.
REQ-018 SHIFT_IN: lasts exactly CHAIN_LEN cycles with scan_en=1. On shift cycle k (k=0..CHAIN_LEN-1), scan_in=pattern[CHAIN_LEN-1-k], so the chain holds pattern after the final shift edge. Then enter CAPTURE.
REQ-019 CAPTURE: lasts exactly CAPTURE_CYCLES cycles with scan_en=0 and scan_in=0. Then enter SHIFT_OUT.
REQ-020 SHIFT_OUT: lasts exactly CHAIN_LEN cycles with scan_en=1 and scan_in=0. Each rising edge does captured <= {captured[CHAIN_LEN-2:0], scan_out}, so after the last edge captured[i] equals the pre-unload state of flop i. Then enter DONE.
REQ-021 DONE: lasts one cycle with done=1, scan_en=0 and pass=(captured==expected_latched). Then enter IDLE. done is 0 in all other states.
REQ-022 Latency: start is accepted at edge E0. scan_en=1 from E0 to E0+CHAIN_LEN. done=1 in the cycle after edge E0+2*CHAIN_LEN+CAPTURE_CYCLES. busy is high for 2*CHAIN_LEN+CAPTURE_CYCLES+1 cycles, which is 10 cycles at the defaults.
REQ-023 Back-to-back tests: start is sampled in the IDLE cycle after DONE, so the minimum gap between tests is one IDLE cycle.
REQ-024 Phase counter: CHAIN_LEN=16 shall not overflow it. It resets to 0 on every state entry.
REQ-025 abort=1 in any non-IDLE state: enter IDLE at the next edge with no done pulse, scan_en=0, and pass and captured cleared to 0. Chain contents are then undefined.
REQ-026 Simultaneous events: abort has priority over start and over all state progression. rst has priority over abort.
REQ-027 pattern and expected may change after acceptance without affecting the test in progress.

Reset
REQ-028 rst=0 at a rising edge: state=IDLE, phase counter=0, scan_en=0, scan_in=0, busy=0, done=0, pass=0, captured=0, latched pattern and expected=0.
REQ-029 Reset mid-test (any state) behaves as REQ-028 at the next edge, with no done pulse. start held during reset is ignored; it is first sampled at the first edge with rst=1.

Verification
REQ-030 Defaults with the controller driving the 4-bit incrementing scan counter: pattern=4'b0101, expected=4'b0110 -> scan_in sequence 0,1,0,1 under scan_en=1; captured=4'b0110; done pulses 10 cycles after acceptance; pass=1.
REQ-031 Wrap-around: pattern=4'b1111, expected=4'b0000 -> captured=4'b0000, pass=1. Same pattern with expected=4'b1111 -> pass=0.
REQ-032 CAPTURE_CYCLES=3, pattern=4'b1110, expected=4'b0001 -> scan_en low for exactly 3 cycles; captured=4'b0001; pass=1; busy high 12 cycles.
REQ-033 start re-pulsed during SHIFT_OUT, and pattern changed mid-test -> ignored; exactly one done pulse; result reflects the originally latched vectors.
REQ-034 abort on the second SHIFT_IN cycle -> IDLE next edge, scan_en=0, no done, pass=0, captured=0. A following start completes normally.
REQ-035 rst=0 during CAPTURE -> next edge all outputs match REQ-028; no done pulse within 20 following cycles without a new start.
